// File: rtl/mips_core.sv
// Five-stage MIPS-like pipeline (IF, ID, EX, MEM, WB) with program-load mode.
// There is no forwarding and no hazard detection. The register file is write-through.
// Jumps resolve in ID and have one delay slot.
module mips_core #(
  parameter int unsigned DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ProgMode,
  input  logic [7:0]  Addr_Prog,
  input  logic [31:0] Data_Prog,
  output logic [7:0]  pc,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h04;
  localparam logic [5:0] OP_J     = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_MUL
  } alu_op_t;

  logic [31:0] imem [256];
  logic [31:0] rf   [32];
  logic [31:0] dmem [2**DMEM_AW];

  logic [31:0] ifid_instr;

  alu_op_t     idex_alu;
  logic [31:0] idex_a, idex_b, idex_st;
  logic [4:0]  idex_dest;
  logic        idex_we, idex_mrd, idex_mwr;

  logic [31:0] exmem_res, exmem_st;
  logic [4:0]  exmem_dest;
  logic        exmem_we, exmem_mrd, exmem_mwr;

  // ID stage fields and decode outputs
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_ra, id_rb, id_rd;
  logic [31:0] id_imm, ra_val, rb_val;
  alu_op_t     d_alu;
  logic [31:0] d_a, d_b, d_st;
  logic [4:0]  d_dest;
  logic        d_we, d_mrd, d_mwr, id_jump;

  logic [31:0]        ex_res;
  logic [DMEM_AW-1:0] mem_addr;
  logic [31:0]        mem_rdata;

  assign id_op    = ifid_instr[31:26];
  assign id_ra    = ifid_instr[25:21];
  assign id_rb    = ifid_instr[20:16];
  assign id_rd    = ifid_instr[15:11];
  assign id_funct = ifid_instr[5:0];
  assign id_imm   = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  // Register read with r0 forced to zero and a same-cycle WB bypass (write-through)
  always_comb begin
    ra_val = rf[id_ra];
    rb_val = rf[id_rb];
    if (wb_en && wb_addr == id_ra) ra_val = wb_data;
    if (wb_en && wb_addr == id_rb) rb_val = wb_data;
    if (id_ra == 5'd0) ra_val = '0;
    if (id_rb == 5'd0) rb_val = '0;
  end

  // Instruction decode. Undefined opcodes and functs leave every write disabled.
  always_comb begin
    d_alu   = ALU_ADD;
    d_a     = rb_val;
    d_b     = id_imm;
    d_st    = ra_val;
    d_dest  = '0;
    d_we    = 1'b0;
    d_mrd   = 1'b0;
    d_mwr   = 1'b0;
    id_jump = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        d_a    = ra_val;
        d_b    = rb_val;
        d_dest = id_rd;
        d_we   = 1'b1;
        case (id_funct)
          6'd0:    d_alu = ALU_ADD;
          6'd1:    d_alu = ALU_SUB;
          6'd2:    d_alu = ALU_AND;
          6'd3:    d_alu = ALU_OR;
          6'd4:    d_alu = ALU_XOR;
          6'd5:    d_alu = ALU_SLT;
          6'd6:    d_alu = ALU_MUL;
          default: d_we  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d_dest = id_ra;
        d_we   = 1'b1;
      end
      OP_LW: begin
        d_dest = id_ra;
        d_we   = 1'b1;
        d_mrd  = 1'b1;
      end
      OP_SW:   d_mwr   = 1'b1;
      OP_J:    id_jump = 1'b1;
      default: ;
    endcase
    // A write to r0 is dropped here, so wb_en only ever flags real writes
    if (d_dest == 5'd0) d_we = 1'b0;
  end

  // EX stage ALU (32-bit wrap-around arithmetic)
  always_comb begin
    ex_res = '0;
    case (idex_alu)
      ALU_ADD: ex_res = idex_a + idex_b;
      ALU_SUB: ex_res = idex_a - idex_b;
      ALU_AND: ex_res = idex_a & idex_b;
      ALU_OR:  ex_res = idex_a | idex_b;
      ALU_XOR: ex_res = idex_a ^ idex_b;
      ALU_SLT: ex_res = {31'd0, $signed(idex_a) < $signed(idex_b)};
      ALU_MUL: ex_res = idex_a * idex_b;
      default: ex_res = '0;
    endcase
  end

  assign mem_addr  = exmem_res[DMEM_AW-1:0];
  assign mem_rdata = dmem[mem_addr];

  // Instruction memory load in program mode (not affected by reset)
  always_ff @(posedge clk) begin
    if (!ProgMode) imem[Addr_Prog] <= Data_Prog;
  end

  // Data memory store on the edge leaving MEM (not affected by reset)
  always_ff @(posedge clk) begin
    if (exmem_mwr) dmem[mem_addr] <= exmem_st;
  end

  // Register file write from WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // PC and pipeline registers. Program mode holds the PC and feeds NOPs into IF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ifid_instr <= '0;
      idex_alu   <= ALU_ADD;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_st    <= '0;
      idex_dest  <= '0;
      idex_we    <= 1'b0;
      idex_mrd   <= 1'b0;
      idex_mwr   <= 1'b0;
      exmem_res  <= '0;
      exmem_st   <= '0;
      exmem_dest <= '0;
      exmem_we   <= 1'b0;
      exmem_mrd  <= 1'b0;
      exmem_mwr  <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      if (ProgMode) begin
        pc         <= id_jump ? ifid_instr[7:0] : pc + 8'd1;
        ifid_instr <= imem[pc];
      end else begin
        ifid_instr <= '0;
      end
      idex_alu   <= d_alu;
      idex_a     <= d_a;
      idex_b     <= d_b;
      idex_st    <= d_st;
      idex_dest  <= d_dest;
      idex_we    <= d_we;
      idex_mrd   <= d_mrd;
      idex_mwr   <= d_mwr;
      exmem_res  <= ex_res;
      exmem_st   <= idex_st;
      exmem_dest <= idex_dest;
      exmem_we   <= idex_we;
      exmem_mrd  <= idex_mrd;
      exmem_mwr  <= idex_mwr;
      wb_en      <= exmem_we;
      wb_addr    <= exmem_dest;
      wb_data    <= exmem_mrd ? mem_rdata : exmem_res;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: reset, write-back timing, stale reads, write-through,
// jump delay slot, load/store, and program-mode freeze/resume.
module tb_mips_core;

  logic        clk;
  logic        reset;
  logic        ProgMode;
  logic [7:0]  Addr_Prog;
  logic [31:0] Data_Prog;
  logic [7:0]  pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  mips_core #(.DMEM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ProgMode  (ProgMode),
    .Addr_Prog (Addr_Prog),
    .Data_Prog (Data_Prog),
    .pc        (pc),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, ".en"}, {31'd0, wb_en}, {31'd0, en});
    if (en) begin
      chk({tag, ".addr"}, {27'd0, wb_addr}, {27'd0, addr});
      chk({tag, ".data"}, wb_data, data);
    end
  endtask

  task automatic prog_word(input logic [7:0] a, input logic [31:0] d);
    ProgMode  = 1'b0;
    Addr_Prog = a;
    Data_Prog = d;
    step();
  endtask

  task automatic prog_clear();
    for (int i = 0; i < 32; i++) prog_word(8'(i), 32'h0);
  endtask

  // Reset pulse between edges, then enter run mode; the next edge is run edge 1
  task automatic start_run();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    ProgMode = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    ProgMode  = 1'b0;
    Addr_Prog = 8'd0;
    Data_Prog = 32'h0;

    // Reset state, both modes
    step(); step();
    chk("rst.pc", {24'd0, pc}, 32'd0);
    chk_wb("rst.p0", 1'b0, 5'd0, 32'd0);
    chk("rst.wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    ProgMode = 1'b1;
    step(); step();
    chk("rst.pc_run", {24'd0, pc}, 32'd0);
    chk_wb("rst.p1", 1'b0, 5'd0, 32'd0);
    reset = 1'b1;

    // ADDI r1=5, ADDI r2=8, 3 NOPs, MUL r3=r2*r1
    prog_clear();
    prog_word(8'd0, 32'h10200005);
    prog_word(8'd1, 32'h10400008);
    prog_word(8'd5, 32'h00411806);
    start_run();
    step(); step(); step();
    chk_wb("A.e3", 1'b0, 5'd0, 32'd0);
    step();
    chk("A.pc4", {24'd0, pc}, 32'd4);
    chk_wb("A.e4", 1'b1, 5'd1, 32'd5);
    step();
    chk_wb("A.e5", 1'b1, 5'd2, 32'd8);
    step();
    chk_wb("A.e6", 1'b0, 5'd0, 32'd0);
    step(); step(); step();
    chk_wb("A.e9", 1'b1, 5'd3, 32'h28);

    // Back-to-back dependency reads the stale r1
    prog_clear();
    prog_word(8'd0, 32'h10200005);
    prog_word(8'd1, 32'h10410003);
    start_run();
    step(); step(); step(); step();
    chk_wb("B.e4", 1'b1, 5'd1, 32'd5);
    step();
    chk_wb("B.e5", 1'b1, 5'd2, 32'd3);

    // Three NOPs between producer and consumer
    prog_clear();
    prog_word(8'd0, 32'h10200005);
    prog_word(8'd4, 32'h10410003);
    start_run();
    for (int i = 0; i < 8; i++) step();
    chk_wb("B2.e8", 1'b1, 5'd2, 32'd8);

    // Two NOPs: only the write-through read sees the new r1
    prog_clear();
    prog_word(8'd0, 32'h10200005);
    prog_word(8'd3, 32'h10410003);
    start_run();
    for (int i = 0; i < 7; i++) step();
    chk_wb("C.e7", 1'b1, 5'd2, 32'd8);

    // J at 3 -> 1; delay slot at 4 increments r1 each pass
    prog_clear();
    prog_word(8'd3, 32'h30000001);
    prog_word(8'd4, 32'h10210001);
    start_run();
    begin
      logic [7:0] pc_exp [10];
      pc_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};
      for (int k = 1; k <= 10; k++) begin
        step();
        chk($sformatf("D.pc%0d", k), {24'd0, pc}, {24'd0, pc_exp[k-1]});
        if (k == 8) chk_wb("D.e8", 1'b1, 5'd1, 32'd1);
      end
    end
    step(); step();
    chk_wb("D.e12", 1'b1, 5'd1, 32'd2);

    // Store r1=9 to dmem[4], load it into r2, ADDI to r0 is invisible
    prog_clear();
    prog_word(8'd0, 32'h10200009);
    prog_word(8'd4, 32'hAC200004);
    prog_word(8'd5, 32'h8C400004);
    prog_word(8'd6, 32'h10000007);
    start_run();
    step(); step(); step(); step();
    chk_wb("E.e4", 1'b1, 5'd1, 32'd9);
    step(); step(); step(); step();
    chk_wb("E.e8_sw", 1'b0, 5'd0, 32'd0);
    step();
    chk_wb("E.e9_lw", 1'b1, 5'd2, 32'd9);
    step();
    chk_wb("E.e10_r0", 1'b0, 5'd0, 32'd0);

    // Freeze mid-run and resume
    prog_clear();
    prog_word(8'd0, 32'h10200005);
    prog_word(8'd1, 32'h10400008);
    prog_word(8'd2, 32'h10600007);
    start_run();
    step(); step();
    chk("F.pc2", {24'd0, pc}, 32'd2);
    ProgMode  = 1'b0;
    Addr_Prog = 8'd200;
    Data_Prog = 32'h0;
    step();
    chk("F.pc_e3", {24'd0, pc}, 32'd2);
    step();
    chk("F.pc_e4", {24'd0, pc}, 32'd2);
    chk_wb("F.e4", 1'b1, 5'd1, 32'd5);
    step();
    chk("F.pc_e5", {24'd0, pc}, 32'd2);
    chk_wb("F.e5", 1'b1, 5'd2, 32'd8);
    step();
    chk("F.pc_e6", {24'd0, pc}, 32'd2);
    chk_wb("F.e6", 1'b0, 5'd0, 32'd0);
    ProgMode = 1'b1;
    step();
    chk("F.pc_e7", {24'd0, pc}, 32'd3);
    step(); step(); step();
    chk_wb("F.e10", 1'b1, 5'd3, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
